// File: rtl/burst_addr_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : burst_pkg
// Purpose  : Shared types, constants and helpers for the AXI4 burst
//            address/beat counter and its next-address sub-block.
// Contents : burst_t, state_t, BOUNDARY_4K, is_legal_wrap_len()
// Revision : 1.0 - initial release
// ============================================================================
package burst_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int BOUNDARY_4K = 4096;

  // AXI4 only allows wrapping bursts of 2, 4, 8 or 16 beats (AxLEN 1/3/7/15).
  function automatic logic is_legal_wrap_len(input logic [31:0] len);
    return (len == 32'd1) || (len == 32'd3) || (len == 32'd7) || (len == 32'd15);
  endfunction

endpackage
`default_nettype wire

// File: rtl/burst_addr_next.sv
`default_nettype none
// ============================================================================
// Module   : burst_addr_next
// Purpose  : Combinational AXI4 next-beat address for FIXED/INCR/WRAP.
//            Shared by the AR and AW channel counters.
// Ports    : addr      - current beat address
//            len       - AxLEN (beats-1)
//            burst     - burst type
//            next_addr - address of the following beat
// Revision : 1.0 - initial release
// ============================================================================
module burst_addr_next
  import burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int DATA_BYTES = 4
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LEN_WIDTH-1:0]  len,
  input  burst_t                burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  localparam int                    c_shift      = $clog2(DATA_BYTES);
  localparam logic [ADDR_WIDTH-1:0] c_step       = ADDR_WIDTH'(DATA_BYTES);
  localparam logic [ADDR_WIDTH-1:0] c_align_mask = ~(c_step - ADDR_WIDTH'(1));

  // Wrap window size in bytes minus one. Legal wrap lengths keep this well
  // below 4 KB, so truncation to ADDR_WIDTH only affects non-wrap bursts
  // where the value is unused.
  logic [ADDR_WIDTH-1:0] w_wrap_mask;
  assign w_wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << c_shift) - ADDR_WIDTH'(1);

  always_comb begin
    next_addr = addr;
    case (burst)
      // Realign so an unaligned first beat lands on the next beat boundary.
      INCR:    next_addr = (addr & c_align_mask) + c_step;
      // Keep the window base, advance the offset modulo the window size.
      WRAP:    next_addr = (addr & ~w_wrap_mask) | ((addr + c_step) & w_wrap_mask);
      default: next_addr = addr;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/counter.sv
`default_nettype none
// ============================================================================
// Module   : counter
// Purpose  : Loadable up-counter. A load takes priority over an increment.
// Ports    : clk, resetn (async, active-low)
//            load_value_enable / load_value - synchronous load
//            enable                         - increment by one
//            count                          - current count
// Revision : 1.0 - initial release
// ============================================================================
module counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_value_enable,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (load_value_enable) begin
      r_count <= load_value;
    end else if (enable) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/burst_addr_counter.sv
`default_nettype none
// ============================================================================
// Module   : burst_addr_counter
// Purpose  : AXI4 burst address/beat counter. Loads a descriptor, rejects
//            illegal ones, then steps one beat per accepted transfer.
// Ports    : clk, resetn (async, active-low)
//            start, start_addr, start_len, start_burst - descriptor load
//            advance  - current beat accepted
//            busy     - burst in progress
//            addr     - current beat address
//            beat_idx - current beat index (0-based)
//            last     - current beat is final (combinational)
//            done     - pulse after final beat accepted
//            err      - pulse on rejected descriptor
// Revision : 1.0 - initial release
// ============================================================================
module burst_addr_counter
  import burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int DATA_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  start_len,
  input  logic [1:0]            start_burst,
  input  logic                  advance,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [LEN_WIDTH-1:0]  beat_idx,
  output logic                  last,
  output logic                  done,
  output logic                  err
);

  // Wide enough for a 4 KB offset plus the largest possible burst length.
  localparam int               c_chk_w   = 13 + LEN_WIDTH;
  localparam int               c_shift   = $clog2(DATA_BYTES);
  localparam logic [11:0]      c_align12 = ~12'(DATA_BYTES - 1);

  state_t                r_state;
  burst_t                r_burst;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_done;
  logic                  r_err;

  burst_t                w_start_burst;
  logic [c_chk_w-1:0]    w_incr_end;
  logic                  w_unaligned;
  logic                  w_reject;
  logic                  w_load;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_next_addr;

  assign w_start_burst = burst_t'(start_burst);

  // End offset of an INCR burst within its 4 KB page, from the aligned start.
  assign w_incr_end = c_chk_w'(start_addr[11:0] & c_align12)
                    + ((c_chk_w'(start_len) + c_chk_w'(1)) << c_shift);

  assign w_unaligned = |(start_addr & ADDR_WIDTH'(DATA_BYTES - 1));

  always_comb begin
    w_reject = 1'b0;
    case (w_start_burst)
      RSVD:    w_reject = 1'b1;
      WRAP:    w_reject = !is_legal_wrap_len(32'(start_len)) || w_unaligned;
      INCR:    w_reject = (w_incr_end > c_chk_w'(BOUNDARY_4K));
      default: w_reject = 1'b0;
    endcase
  end

  assign w_load = start && (r_state == IDLE) && !w_reject;
  assign w_last = busy && (beat_idx == r_len);

  burst_addr_next #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .DATA_BYTES (DATA_BYTES)
  ) u_addr_next (
    .addr      (r_addr),
    .len       (r_len),
    .burst     (r_burst),
    .next_addr (w_next_addr)
  );

  counter #(
    .WIDTH (LEN_WIDTH)
  ) u_beat_cnt (
    .clk               (clk),
    .resetn            (resetn),
    .load_value_enable (w_load),
    .load_value        ('0),
    .enable            (busy && advance && !w_last),
    .count             (beat_idx)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_burst <= FIXED;
      r_len   <= '0;
      r_addr  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_reject) begin
              r_err <= 1'b1;
            end else begin
              r_state <= ACTIVE;
              r_burst <= w_start_burst;
              r_len   <= start_len;
              r_addr  <= start_addr;
            end
          end
        end
        ACTIVE: begin
          if (advance) begin
            if (w_last) begin
              // addr and beat_idx keep the final beat's values.
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else begin
              r_addr <= w_next_addr;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state == ACTIVE);
  assign addr = r_addr;
  assign last = w_last;
  assign done = r_done;
  assign err  = r_err;

endmodule
`default_nettype wire

// File: doc/burst_addr_counter.md
# burst_addr_counter

Parametrised AXI4 burst address/beat counter for the DMA read and write channels. It loads a burst descriptor (start address, AxLEN, AxBURST), then advances one beat per accepted data transfer. Per beat it produces the AXI-correct address for FIXED, INCR and WRAP bursts, a beat index and a last flag. It rejects illegal descriptors at load time and sits between the DMA descriptor engine and the AXI4 R/W data-beat logic.

## Interface
- ADDR_WIDTH, 32: address width; must be ≥ 12.
- LEN_WIDTH, 8: width of AxLEN, which holds beats−1.
- DATA_BYTES, 4: bytes per beat; power of 2, from 1 to 128.
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- start  in  1  load descriptor; accepted only while busy=0.
- start_addr  in  ADDR_WIDTH  first beat address.
- start_len  in  LEN_WIDTH  beats−1.
- start_burst  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- advance  in  1  current beat accepted by the AXI side.
- busy  out  1  burst in progress.
- addr  out  ADDR_WIDTH  address of the current beat.
- beat_idx  out  LEN_WIDTH  index of the current beat, 0-based.
- last  out  1  current beat is the final beat.
- done  out  1  one-cycle pulse after the final beat is accepted.
- err  out  1  one-cycle pulse when a descriptor is rejected.

## Operation
- FSM states:
  - IDLE → ACTIVE on a legal start.
  - ACTIVE → IDLE on advance && last.
- Start check, evaluated in IDLE while start=1. The descriptor is rejected (err pulse, state stays IDLE, outputs unchanged) if any of these hold:
  - burst=11.
  - WRAP with start_len ∉ {1,3,7,15}.
  - WRAP with start_addr not aligned to DATA_BYTES.
  - INCR where the aligned start offset plus the burst crosses 4 KB: (start_addr[11:0] & ~(DATA_BYTES−1)) + (start_len+1)·DATA_BYTES > 4096.
- Check arithmetic uses 13 + LEN_WIDTH bits, so no overflow is possible.
- Legal start: latch len and burst, addr ← start_addr, beat_idx ← 0, busy ← 1.
- advance in ACTIVE with last=0: beat_idx+1, and addr updates by burst type:
  - FIXED: addr unchanged.
  - INCR: addr ← (addr & ~(DATA_BYTES−1)) + DATA_BYTES. An unaligned first beat is realigned on the next beat.
  - WRAP: with W = (len+1)·DATA_BYTES, addr ← (addr & ~(W−1)) | ((addr + DATA_BYTES) & (W−1)).
- addr arithmetic is modulo 2^ADDR_WIDTH.
- advance in ACTIVE with last=1: busy ← 0, done pulses; addr and beat_idx hold their final values.
- last = busy && (beat_idx == len), decoded combinationally from registers.
- advance while IDLE: ignored.
- start while busy: ignored, no err.
- advance=0: all state holds, so stalls of any length are allowed.

## Timing
- Reset values: busy 0, addr 0, beat_idx 0, last 0, done 0, err 0, state IDLE.
- Reset asserted mid-burst aborts immediately with no done pulse.
- Latency:
  - start → busy=1, addr valid: 1 cycle.
  - advance → next addr: 1 cycle.
  - Final advance → busy=0 and done=1: 1 cycle.
  - Illegal start → err=1: 1 cycle.
- Back-to-back bursts: start is accepted in the cycle done=1, since busy=0 then. The new burst is busy again the following cycle, with no bubble beyond that.
- A single-beat burst (len=0): last=1 on the first ACTIVE cycle.
- All outputs are registered except last.

## Structure
- Package burst_pkg holds:
  - burst_t enum: FIXED, INCR, WRAP, RSVD.
  - state_t enum: IDLE, ACTIVE.
  - BOUNDARY_4K = 4096 localparam.
  - Function is_legal_wrap_len.
- The beat index instantiates the team's counter block:
  - WIDTH=LEN_WIDTH.
  - load_value_enable on legal start, with load_value 0.
  - enable on advance && !last.
- Sub-module burst_addr_next: combinational next-address calculation for FIXED/INCR/WRAP, for reuse by the AR and AW channels.

## Test plan
All scenarios use DATA_BYTES=4.
- INCR, start_addr 0x1000, len 3, advance held high → addr 0x1000, 0x1004, 0x1008, 0x100C. last on beat 3; done one cycle after; busy=0.
- WRAP, start_addr 0x1008, len 3 → addr 0x1008, 0x100C, 0x1000, 0x1004; last on the 4th beat.
- FIXED, start_addr 0x2000, len 2, advance toggled 1/0 → addr stays 0x2000 for 3 beats; beat_idx 0, 1, 2 advances only on advance=1.
- Illegal descriptors, each giving an err pulse with busy staying 0:
  - INCR 0x0FF8, len 3 (crosses 4 KB).
  - WRAP len 2.
  - WRAP addr 0x1002.
  - burst=11.
- Unaligned INCR, start_addr 0x1002, len 1 → addr 0x1002 then 0x1004.
- Control corner cases:
  - start during a burst: ignored.
  - New start in the done cycle: accepted; busy=1 the next cycle.
  - resetn low mid-burst: all outputs 0 asynchronously, no done pulse.
